// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Purpose
//   Two-port arbiter and sequencer in front of a single memory bank. Port 0
//   (instruction side) and port 1 (data side) each issue full-line read or
//   write requests. One request is granted at a time, round-robin on ties.
//   The bank is driven for MEM_LATENCY cycles. The captured read line and a
//   one-cycle ack are then returned to the granted port.
//
//   Sequence: IDLE -> BUSY (MEM_LATENCY cycles) -> RESP (1 cycle) -> IDLE.
//   - A grant at edge k gives an ack that is high during the cycle after
//     edge k+MEM_LATENCY.
//   - Back-to-back grants are MEM_LATENCY+2 cycles apart.
//   - Every output is a flop.
//
// Parameters
//   MEMORY_LINE_LENGTH   bits per line (bank data width)
//   MEMORY_ADDRESS_SIZE  bank address width
//   MEM_LATENCY          cycles the bank is held per access (>= 1)
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   req0, req1     in   request, held high until that port's ack
//   we0, we1       in   1 = write line, 0 = read line (stable while req high)
//   addr0, addr1   in   line address (stable while req high)
//   wdata0, wdata1 in   write line (stable while req high)
//   ack0, ack1     out  one-cycle completion pulse
//   rdata0, rdata1 out  last line read by that port (valid while ack high)
//   busy           out  high while an access is in BUSY or RESP
//   mem_addr       out  bank address
//   mem_data_in    out  bank write data
//   mem_write      out  bank write strobe (one cycle per write access)
//   mem_data_out   in   bank read data
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int MEMORY_LINE_LENGTH  = 256,
    parameter int MEMORY_ADDRESS_SIZE = 2,
    parameter int MEM_LATENCY         = 4
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           req0,
    input  logic                           we0,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] addr0,
    input  logic [MEMORY_LINE_LENGTH-1:0]  wdata0,
    output logic                           ack0,
    output logic [MEMORY_LINE_LENGTH-1:0]  rdata0,

    input  logic                           req1,
    input  logic                           we1,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] addr1,
    input  logic [MEMORY_LINE_LENGTH-1:0]  wdata1,
    output logic                           ack1,
    output logic [MEMORY_LINE_LENGTH-1:0]  rdata1,

    output logic                           busy,

    output logic [MEMORY_ADDRESS_SIZE-1:0] mem_addr,
    output logic [MEMORY_LINE_LENGTH-1:0]  mem_data_in,
    output logic                           mem_write,
    input  logic [MEMORY_LINE_LENGTH-1:0]  mem_data_out
);

    // Counter wide enough to hold MEM_LATENCY-1. It is never narrower than
    // one bit, so MEM_LATENCY = 1 still builds.
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Registered state.
    state_t                           state;
    logic [CNT_W-1:0]                 cnt;
    logic                             last_grant;  // port served most recently
    logic                             grant;       // port owning the current access
    logic                             we_lat;      // direction of the current access

    // Next-state values.
    state_t                           state_next;
    logic [CNT_W-1:0]                 cnt_next;
    logic                             last_grant_next;
    logic                             grant_next;
    logic                             we_next;
    logic [MEMORY_ADDRESS_SIZE-1:0]   mem_addr_next;
    logic [MEMORY_LINE_LENGTH-1:0]    mem_data_in_next;
    logic                             mem_write_next;
    logic                             busy_next;
    logic                             ack0_next;
    logic                             ack1_next;
    logic [MEMORY_LINE_LENGTH-1:0]    rdata0_next;
    logic [MEMORY_LINE_LENGTH-1:0]    rdata1_next;

    // Arbitration helpers.
    logic                             win;
    logic                             win_we;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so that every
    // flop samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;  // port 0 wins the first tie
            grant       <= 1'b0;
            we_lat      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            last_grant  <= last_grant_next;
            grant       <= grant_next;
            we_lat      <= we_next;
            mem_addr    <= mem_addr_next;
            mem_data_in <= mem_data_in_next;
            mem_write   <= mem_write_next;
            busy        <= busy_next;
            ack0        <= ack0_next;
            ack1        <= ack1_next;
            rdata0      <= rdata0_next;
            rdata1      <= rdata1_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written here gets a default at the top, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        last_grant_next  = last_grant;
        grant_next       = grant;
        we_next          = we_lat;
        mem_addr_next    = mem_addr;
        mem_data_in_next = mem_data_in;
        mem_write_next   = 1'b0;
        busy_next        = busy;
        ack0_next        = 1'b0;
        ack1_next        = 1'b0;
        rdata0_next      = rdata0;
        rdata1_next      = rdata1;
        win              = 1'b0;
        win_we           = 1'b0;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (req0 || req1) begin
                    // A sole requester wins. On a tie, the port not served last wins.
                    win    = (req0 && req1) ? ~last_grant : req1;
                    win_we = win ? we1 : we0;

                    grant_next       = win;
                    last_grant_next  = win;
                    we_next          = win_we;
                    mem_addr_next    = win ? addr1 : addr0;
                    mem_data_in_next = win ? wdata1 : wdata0;
                    cnt_next         = CNT_LOAD;
                    busy_next        = 1'b1;
                    state_next       = BUSY;
                    // With a one-cycle latency, the first BUSY cycle is also
                    // the cnt == 0 cycle, so the write strobe is armed here.
                    mem_write_next   = (MEM_LATENCY == 1) && win_we;
                end
            end

            BUSY: begin
                if (cnt == CNT_ZERO) begin
                    // The bank line is valid by now. Capture it for reads only.
                    if (!we_lat) begin
                        if (grant) rdata1_next = mem_data_out;
                        else       rdata0_next = mem_data_out;
                    end
                    if (grant) ack1_next = 1'b1;
                    else       ack0_next = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                    // Raise the strobe for the cycle in which cnt reads zero.
                    mem_write_next = (cnt == CNT_ONE) && we_lat;
                end
            end

            RESP: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    localparam int W      = 256;
    localparam int AW     = 2;
    localparam int LAT    = 4;
    localparam int LAT_B  = 1;
    localparam int N_RAND = 800;
    localparam int DRAIN  = 25;

    typedef struct packed {
        int            ack_at;   // cycle index of first ack, -1 if none
        int            n_ack;    // ack cycles seen on the requesting port
        int            n_wr;     // mem_write cycles seen
        int            wr_at;    // cycle index of last mem_write
        int            n_other;  // ack cycles seen on the other port
        logic [AW-1:0] wr_addr;
        logic [W-1:0]  wr_data;
        logic [W-1:0]  rd;
    } result_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A (MEM_LATENCY = 4)
    logic          req0, req1, we0, we1, ack0, ack1, busy, mem_write;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [W-1:0]  wdata0, wdata1, rdata0, rdata1, mem_data_in, mem_data_out;

    // Instance B (MEM_LATENCY = 1)
    logic          req0_b, req1_b, we0_b, we1_b, ack0_b, ack1_b, busy_b, mem_write_b;
    logic [AW-1:0] addr0_b, addr1_b, mem_addr_b;
    logic [W-1:0]  wdata0_b, wdata1_b, rdata0_b, rdata1_b, mem_data_in_b, mem_data_out_b;

    // Bank models. Reads are combinational and writes land on the clock edge.
    logic [W-1:0]  bank   [4];
    logic [W-1:0]  bank_b [4];
    logic          preload_en;
    logic [AW-1:0] preload_addr;
    logic [W-1:0]  preload_data;
    logic [W-1:0]  shadow   [4];
    logic [W-1:0]  shadow_b [4];

    always @(posedge clk) begin
        if (preload_en) begin
            bank[preload_addr]   <= preload_data;
            bank_b[preload_addr] <= preload_data;
        end else begin
            if (mem_write)   bank[mem_addr]     <= mem_data_in;
            if (mem_write_b) bank_b[mem_addr_b] <= mem_data_in_b;
        end
    end
    assign mem_data_out   = bank[mem_addr];
    assign mem_data_out_b = bank_b[mem_addr_b];

    memory_arbiter #(.MEMORY_LINE_LENGTH(W), .MEMORY_ADDRESS_SIZE(AW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write(mem_write), .mem_data_out(mem_data_out)
    );

    memory_arbiter #(.MEMORY_LINE_LENGTH(W), .MEMORY_ADDRESS_SIZE(AW), .MEM_LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b), .rdata1(rdata1_b),
        .busy(busy_b), .mem_addr(mem_addr_b), .mem_data_in(mem_data_in_b),
        .mem_write(mem_write_b), .mem_data_out(mem_data_out_b)
    );

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        preload_addr = a;
        preload_data = d;
        preload_en   = 1'b1;
        @(posedge clk);
        #1 preload_en = 1'b0;
    endtask

    // Issue one request and observe it; each test makes its own comparisons.
    task automatic run_single(input bit inst, input bit port, input logic we,
                              input logic [AW-1:0] a, input logic [W-1:0] d,
                              output result_t r);
        logic mine, other, mw;
        @(negedge clk);
        if (inst) begin
            req0_b = 1'b1; we0_b = we; addr0_b = a; wdata0_b = d;
        end else if (port) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end
        r = '0;
        r.ack_at = -1;
        r.wr_at  = -1;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            mine  = inst ? ack0_b : (port ? ack1 : ack0);
            other = inst ? ack1_b : (port ? ack0 : ack1);
            mw    = inst ? mem_write_b : mem_write;
            if (mw === 1'b1) begin
                r.n_wr++;
                r.wr_at   = i;
                r.wr_addr = inst ? mem_addr_b : mem_addr;
                r.wr_data = inst ? mem_data_in_b : mem_data_in;
            end
            if (other === 1'b1) r.n_other++;
            if (mine === 1'b1) begin
                r.n_ack++;
                if (r.ack_at < 0) begin
                    r.ack_at = i;
                    r.rd = inst ? rdata0_b : (port ? rdata1 : rdata0);
                end
                if (inst) req0_b = 1'b0;
                else if (port) req1 = 1'b0;
                else req0 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        req0_b = 0; req1_b = 0; we0_b = 0; we1_b = 0; addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
        preload_en = 0; preload_addr = '0; preload_data = '0;
        @(posedge clk);
        #1;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %b exp 0", ack0); end
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1 got %b exp 0", ack1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
        checks++; if (mem_data_in !== '0) begin errors++; $display("FAIL reset_mem_data_in got %h exp 0", mem_data_in); end
        checks++; if (rdata0 !== '0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", rdata0); end
        checks++; if (rdata1 !== '0) begin errors++; $display("FAIL reset_rdata1 got %h exp 0", rdata1); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b exp 0", busy_b); end
        checks++; if (rdata1_b !== '0) begin errors++; $display("FAIL reset_rdata1_b got %h exp 0", rdata1_b); end
        for (int a = 0; a < 4; a++) begin
            shadow[a]   = rand_line();
            shadow_b[a] = shadow[a];
            preload(AW'(a), shadow[a]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_read_single();
        result_t r;
        run_single(1'b0, 1'b0, 1'b0, AW'(1), rand_line(), r);
        checks++; if (r.ack_at !== LAT) begin errors++; $display("FAIL read_ack_at got %0d exp %0d", r.ack_at, LAT); end
        checks++; if (r.n_ack !== 1) begin errors++; $display("FAIL read_ack_len got %0d exp 1", r.n_ack); end
        checks++; if (r.rd !== shadow[1]) begin errors++; $display("FAIL read_rdata0 got %h exp %h", r.rd, shadow[1]); end
        checks++; if (r.n_wr !== 0) begin errors++; $display("FAIL read_mem_write got %0d cycles exp 0", r.n_wr); end
        checks++; if (r.n_other !== 0) begin errors++; $display("FAIL read_ack1 got %0d cycles exp 0", r.n_other); end
    endtask

    task automatic test_write();
        result_t r;
        logic [W-1:0] w;
        w = rand_line();
        run_single(1'b0, 1'b1, 1'b1, AW'(3), w, r);
        shadow[3] = w;
        checks++; if (r.n_wr !== 1) begin errors++; $display("FAIL write_count got %0d exp 1", r.n_wr); end
        checks++; if (r.wr_at !== LAT - 1) begin errors++; $display("FAIL write_at got %0d exp %0d", r.wr_at, LAT - 1); end
        checks++; if (r.wr_addr !== AW'(3)) begin errors++; $display("FAIL write_addr got %0d exp 3", r.wr_addr); end
        checks++; if (r.wr_data !== w) begin errors++; $display("FAIL write_data got %h exp %h", r.wr_data, w); end
        checks++; if (r.ack_at !== LAT) begin errors++; $display("FAIL write_ack_at got %0d exp %0d", r.ack_at, LAT); end
        checks++; if (rdata1 !== '0) begin errors++; $display("FAIL write_rdata1_held got %h exp 0", rdata1); end
        run_single(1'b0, 1'b0, 1'b0, AW'(3), rand_line(), r);
        checks++; if (r.rd !== w) begin errors++; $display("FAIL write_readback got %h exp %h", r.rd, w); end
    endtask

    task automatic test_tie();
        int a0, a1;
        logic [W-1:0] r0, r1;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = AW'(0);
        req1 = 1'b1; we1 = 1'b0; addr1 = AW'(1);
        a0 = -1; a1 = -1; r0 = '0; r1 = '0;
        for (int i = 0; i < 3 * LAT + 6; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 && a0 < 0) begin a0 = i; r0 = rdata0; req0 = 1'b0; end
            if (ack1 === 1'b1 && a1 < 0) begin a1 = i; r1 = rdata1; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (a0 !== LAT) begin errors++; $display("FAIL tie_ack0_at got %0d exp %0d", a0, LAT); end
        checks++; if (a1 !== 2 * LAT + 2) begin errors++; $display("FAIL tie_ack1_at got %0d exp %0d", a1, 2 * LAT + 2); end
        checks++; if (r0 !== shadow[0]) begin errors++; $display("FAIL tie_rdata0 got %h exp %h", r0, shadow[0]); end
        checks++; if (r1 !== shadow[1]) begin errors++; $display("FAIL tie_rdata1 got %h exp %h", r1, shadow[1]); end
    endtask

    task automatic test_alternate();
        int order[4];
        int at[4];
        int exp_order[4];
        int n;
        exp_order = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin order[k] = -1; at[k] = 0; end
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = AW'(0);
        req1 = 1'b1; we1 = 1'b0; addr1 = AW'(1);
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                order[n] = (ack1 === 1'b1) ? 1 : 0;
                at[n] = i;
                n++;
                if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL alt_count got %0d exp 4", n); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (order[k] !== exp_order[k]) begin errors++; $display("FAIL alt_order[%0d] got %0d exp %0d", k, order[k], exp_order[k]); end
        end
        for (int k = 1; k < 4; k++) begin
            checks++; if (at[k] - at[k-1] !== LAT + 2) begin errors++; $display("FAIL alt_spacing[%0d] got %0d exp %0d", k, at[k] - at[k-1], LAT + 2); end
        end
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        logic [W-1:0] w;
        int mw, acks;
        result_t r;
        w = ~shadow[2];
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = AW'(2); wdata1 = w;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL midrst_mem_write got %b exp 0", mem_write); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL midrst_mem_addr got %0d exp 0", mem_addr); end
        checks++; if (mem_data_in !== '0) begin errors++; $display("FAIL midrst_mem_data_in got %h exp 0", mem_data_in); end
        checks++; if (rdata0 !== '0) begin errors++; $display("FAIL midrst_rdata0 got %h exp 0", rdata0); end
        checks++; if (rdata1 !== '0) begin errors++; $display("FAIL midrst_rdata1 got %h exp 0", rdata1); end
        req1 = 1'b0; we1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mw = 0; acks = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (mem_write === 1'b1) mw++;
            if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
        end
        checks++; if (mw !== 0) begin errors++; $display("FAIL midrst_no_write got %0d exp 0", mw); end
        checks++; if (acks !== 0) begin errors++; $display("FAIL midrst_no_ack got %0d exp 0", acks); end
        checks++; if (bank[2] !== shadow[2]) begin errors++; $display("FAIL midrst_bank got %h exp %h", bank[2], shadow[2]); end
        run_single(1'b0, 1'b0, 1'b0, AW'(2), rand_line(), r);
        checks++; if (r.ack_at !== LAT) begin errors++; $display("FAIL midrst_next_ack_at got %0d exp %0d", r.ack_at, LAT); end
        checks++; if (r.rd !== shadow[2]) begin errors++; $display("FAIL midrst_next_rdata got %h exp %h", r.rd, shadow[2]); end
    endtask

    task automatic test_latency1();
        result_t r;
        logic [W-1:0] w;
        w = rand_line();
        run_single(1'b1, 1'b0, 1'b1, AW'(1), w, r);
        shadow_b[1] = w;
        checks++; if (r.n_wr !== 1) begin errors++; $display("FAIL lat1_write_count got %0d exp 1", r.n_wr); end
        checks++; if (r.wr_at !== 0) begin errors++; $display("FAIL lat1_write_at got %0d exp 0", r.wr_at); end
        checks++; if (r.ack_at !== LAT_B) begin errors++; $display("FAIL lat1_write_ack_at got %0d exp %0d", r.ack_at, LAT_B); end
        run_single(1'b1, 1'b0, 1'b0, AW'(2), rand_line(), r);
        checks++; if (r.ack_at !== LAT_B) begin errors++; $display("FAIL lat1_read_ack_at got %0d exp %0d", r.ack_at, LAT_B); end
        checks++; if (r.n_ack !== 1) begin errors++; $display("FAIL lat1_read_ack_len got %0d exp 1", r.n_ack); end
        checks++; if (r.rd !== shadow_b[2]) begin errors++; $display("FAIL lat1_read_rdata got %h exp %h", r.rd, shadow_b[2]); end
        checks++; if (r.n_wr !== 0) begin errors++; $display("FAIL lat1_read_mem_write got %0d exp 0", r.n_wr); end
        checks++; if (r.n_other !== 0) begin errors++; $display("FAIL lat1_ack1 got %0d exp 0", r.n_other); end
        run_single(1'b1, 1'b0, 1'b0, AW'(1), rand_line(), r);
        checks++; if (r.rd !== shadow_b[1]) begin errors++; $display("FAIL lat1_readback got %h exp %h", r.rd, shadow_b[1]); end
    endtask

    // Random traffic on both ports against a transaction-level model. A grant
    // taken at edge g makes busy high for cycles g..g+LAT and mem_write high
    // in cycle g+LAT-1 for writes. The ack is high in cycle g+LAT, and the
    // next grant can come no earlier than edge g+LAT+2.
    task automatic test_random();
        logic [W-1:0]  mem_model [4];
        logic [W-1:0]  exp_rd0, exp_rd1, g_wdata;
        logic [AW-1:0] g_addr;
        logic          g_we, e_busy, e_ack0, e_ack1, e_mw;
        bit            have_txn;
        int            g_edge, g_port, free_at, cyc, d, last, win, n_ack_exp, n_ack_obs;
        @(negedge clk);
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        for (int a = 0; a < 4; a++) begin
            mem_model[a] = rand_line();
            preload(AW'(a), mem_model[a]);
        end
        @(negedge clk);
        reset = 1'b0;
        have_txn = 0; free_at = 0; cyc = 0; last = 1; g_edge = 0; g_port = 0;
        g_we = 0; g_addr = '0; g_wdata = '0; exp_rd0 = '0; exp_rd1 = '0;
        n_ack_exp = 0; n_ack_obs = 0;
        for (int n = 0; n < N_RAND; n++) begin
            @(negedge clk);
            cyc++;
            d      = cyc - g_edge;
            e_busy = have_txn && d <= LAT;
            e_ack0 = have_txn && d == LAT && g_port == 0;
            e_ack1 = have_txn && d == LAT && g_port == 1;
            e_mw   = have_txn && d == LAT - 1 && g_we;
            if (e_ack0 && !g_we) exp_rd0 = mem_model[g_addr];
            if (e_ack1 && !g_we) exp_rd1 = mem_model[g_addr];
            if (e_ack0 || e_ack1) n_ack_exp++;
            if (ack0 === 1'b1 || ack1 === 1'b1) n_ack_obs++;
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, busy, e_busy); end
            checks++; if (ack0 !== e_ack0) begin errors++; $display("FAIL rnd_ack0 cyc %0d got %b exp %b", cyc, ack0, e_ack0); end
            checks++; if (ack1 !== e_ack1) begin errors++; $display("FAIL rnd_ack1 cyc %0d got %b exp %b", cyc, ack1, e_ack1); end
            checks++; if (mem_write !== e_mw) begin errors++; $display("FAIL rnd_mem_write cyc %0d got %b exp %b", cyc, mem_write, e_mw); end
            checks++; if (rdata0 !== exp_rd0) begin errors++; $display("FAIL rnd_rdata0 cyc %0d got %h exp %h", cyc, rdata0, exp_rd0); end
            checks++; if (rdata1 !== exp_rd1) begin errors++; $display("FAIL rnd_rdata1 cyc %0d got %h exp %h", cyc, rdata1, exp_rd1); end
            if (e_mw) begin
                checks++; if (mem_addr !== g_addr) begin errors++; $display("FAIL rnd_mem_addr cyc %0d got %0d exp %0d", cyc, mem_addr, g_addr); end
                checks++; if (mem_data_in !== g_wdata) begin errors++; $display("FAIL rnd_mem_data_in cyc %0d got %h exp %h", cyc, mem_data_in, g_wdata); end
                mem_model[g_addr] = g_wdata;
            end
            if (e_ack0) req0 = 1'b0;
            if (e_ack1) req1 = 1'b0;
            if (n < N_RAND - DRAIN) begin
                if (!req0 && $urandom_range(0, 2) == 0) begin
                    req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = AW'($urandom_range(0, 3)); wdata0 = rand_line();
                end
                if (!req1 && $urandom_range(0, 2) == 0) begin
                    req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = AW'($urandom_range(0, 3)); wdata1 = rand_line();
                end
            end
            if (cyc + 1 >= free_at && (req0 || req1)) begin
                win      = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
                have_txn = 1;
                g_edge   = cyc + 1;
                g_port   = win;
                g_we     = (win == 1) ? we1 : we0;
                g_addr   = (win == 1) ? addr1 : addr0;
                g_wdata  = (win == 1) ? wdata1 : wdata0;
                last     = win;
                free_at  = g_edge + LAT + 2;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (n_ack_obs !== n_ack_exp) begin errors++; $display("FAIL rnd_ack_total got %0d exp %0d", n_ack_obs, n_ack_exp); end
    endtask

    initial begin
        test_reset();
        test_read_single();
        test_write();
        test_tie();
        test_alternate();
        test_reset_mid_write();
        test_latency1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
